// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - chunked pipelined add/subtract with valid/ready and full-pipeline stall
// Optional signed overflow output enabled by defining PIPELINED_ADDER_OVERFLOW_EN.
module pipelined_adder #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_add1,
  input  logic [WIDTH-1:0] i_add2,
  input  logic             i_carry,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry,
  output logic             o_overflow
);

  localparam int CW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] carry_q, carry_d;
  // a/b hold the not-yet-added upper chunks, r holds the finished lower chunks
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];
  logic [WIDTH-1:0]  r_q [STAGES];
  logic [WIDTH-1:0]  r_d [STAGES];

  logic             adv;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] r_in;
  logic             c_in;
  logic             v_in;
  logic [CW:0]      sum;

`ifdef PIPELINED_ADDER_OVERFLOW_EN
  logic ovf_q, ovf_d;
`endif

  assign adv = ~valid_q[LAST] | i_ready;

  always_comb begin
    valid_d = valid_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    a_in    = '0;
    b_in    = '0;
    r_in    = '0;
    c_in    = 1'b0;
    v_in    = 1'b0;
    sum     = '0;
`ifdef PIPELINED_ADDER_OVERFLOW_EN
    ovf_d   = ovf_q;
`endif
    if (adv) begin
      for (int s = 0; s < STAGES; s++) begin
        if (s == 0) begin
          a_in = i_add1;
          b_in = i_sub ? ~i_add2 : i_add2;
          r_in = '0;
          c_in = i_carry ^ i_sub;
          v_in = i_valid;
        end else begin
          a_in = a_q[s-1];
          b_in = b_q[s-1];
          r_in = r_q[s-1];
          c_in = carry_q[s-1];
          v_in = valid_q[s-1];
        end
        sum = {1'b0, a_in[s*CW +: CW]} + {1'b0, b_in[s*CW +: CW]} + {{CW{1'b0}}, c_in};
        r_in[s*CW +: CW] = sum[CW-1:0];
        a_d[s]     = a_in;
        b_d[s]     = b_in;
        r_d[s]     = r_in;
        carry_d[s] = sum[CW];
        valid_d[s] = v_in;
`ifdef PIPELINED_ADDER_OVERFLOW_EN
        if (s == LAST) begin
          ovf_d = (a_in[WIDTH-1] == b_in[WIDTH-1]) & (r_in[WIDTH-1] != a_in[WIDTH-1]);
        end
`endif
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= '0;
      carry_q <= '0;
      for (int s = 0; s < STAGES; s++) begin
        a_q[s] <= '0;
        b_q[s] <= '0;
        r_q[s] <= '0;
      end
`ifdef PIPELINED_ADDER_OVERFLOW_EN
      ovf_q <= 1'b0;
`endif
    end else begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      for (int s = 0; s < STAGES; s++) begin
        a_q[s] <= a_d[s];
        b_q[s] <= b_d[s];
        r_q[s] <= r_d[s];
      end
`ifdef PIPELINED_ADDER_OVERFLOW_EN
      ovf_q <= ovf_d;
`endif
    end
  end

  assign o_ready  = adv;
  assign o_valid  = valid_q[LAST];
  assign o_result = r_q[LAST];
  assign o_carry  = carry_q[LAST];
`ifdef PIPELINED_ADDER_OVERFLOW_EN
  assign o_overflow = ovf_q & valid_q[LAST];
`else
  assign o_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - scoreboard bench for pipelined_adder (8x2, 64x4, 64x1)
// Overflow expectations follow PIPELINED_ADDER_OVERFLOW_EN.
module tb_pipelined_adder;

  logic       clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_valid = 1'b0;
  logic       i_ready = 1'b1;
  logic [7:0] i_add1 = '0;
  logic [7:0] i_add2 = '0;
  logic       i_carry = 1'b0;
  logic       i_sub = 1'b0;
  logic       o_ready, o_valid, o_carry, o_overflow;
  logic [7:0] o_result;

  logic        w_valid = 1'b0;
  logic        w_ready = 1'b1;
  logic [63:0] w_add1 = '0;
  logic [63:0] w_add2 = '0;
  logic        w_carry = 1'b0;
  logic        w_sub = 1'b0;
  logic        w4_o_ready, w4_o_valid, w4_o_carry, w4_o_overflow;
  logic [63:0] w4_o_result;
  logic        w1_o_ready, w1_o_valid, w1_o_carry, w1_o_overflow;
  logic [63:0] w1_o_result;

  int n_cmp = 0;
  int n_bad = 0;
  bit rand_mode = 1'b0;
  logic [9:0] sb_q[$];

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(8), .STAGES(2)) u_dut (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_add1(i_add1), .i_add2(i_add2), .i_carry(i_carry), .i_sub(i_sub),
    .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result),
    .o_carry(o_carry), .o_overflow(o_overflow)
  );

  pipelined_adder #(.WIDTH(64), .STAGES(4)) u_w4 (
    .i_clk(clk), .i_rst(i_rst), .i_valid(w_valid), .o_ready(w4_o_ready),
    .i_add1(w_add1), .i_add2(w_add2), .i_carry(w_carry), .i_sub(w_sub),
    .o_valid(w4_o_valid), .i_ready(w_ready), .o_result(w4_o_result),
    .o_carry(w4_o_carry), .o_overflow(w4_o_overflow)
  );

  pipelined_adder #(.WIDTH(64), .STAGES(1)) u_w1 (
    .i_clk(clk), .i_rst(i_rst), .i_valid(w_valid), .o_ready(w1_o_ready),
    .i_add1(w_add1), .i_add2(w_add2), .i_carry(w_carry), .i_sub(w_sub),
    .o_valid(w1_o_valid), .i_ready(w_ready), .o_result(w1_o_result),
    .o_carry(w1_o_carry), .o_overflow(w1_o_overflow)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: add is a+b+c, subtract is a-b-c; carry means no borrow on subtract.
  function automatic logic [9:0] model8(input logic [7:0] a, input logic [7:0] b,
                                        input logic c, input logic s);
    int u, sv;
    logic cy, ov;
    if (!s) begin
      u  = int'(a) + int'(b) + int'(c);
      sv = int'($signed(a)) + int'($signed(b)) + int'(c);
      cy = (u > 255);
    end else begin
      u  = int'(a) - int'(b) - int'(c);
      sv = int'($signed(a)) - int'($signed(b)) - int'(c);
      cy = (u >= 0);
    end
`ifdef PIPELINED_ADDER_OVERFLOW_EN
    ov = (sv > 127) || (sv < -128);
`else
    ov = 1'b0;
`endif
    return {ov, cy, u[7:0]};
  endfunction

  logic       hold_p = 1'b0;
  logic [7:0] res_p;
  logic       car_p, ov_p;
  logic [9:0] exp_e;

  always @(negedge clk) begin
    chk("o_ready_rule", o_ready, !o_valid || i_ready);
    if (hold_p) begin
      chk("hold_valid", o_valid, 1'b1);
      chk("hold_result", o_result, res_p);
      chk("hold_carry", o_carry, car_p);
      chk("hold_ovf", o_overflow, ov_p);
    end
    if (i_rst) begin
      sb_q.delete();
    end else begin
      if (o_valid && i_ready) begin
        if (sb_q.size() == 0) begin
          chk("spurious_out", o_valid, 1'b0);
        end else begin
          exp_e = sb_q.pop_front();
          chk("sb_result", o_result, exp_e[7:0]);
          chk("sb_carry", o_carry, exp_e[8]);
          chk("sb_ovf", o_overflow, exp_e[9]);
        end
      end
      if (i_valid && o_ready) sb_q.push_back(model8(i_add1, i_add2, i_carry, i_sub));
    end
    hold_p = !i_rst && o_valid && !i_ready;
    res_p  = o_result;
    car_p  = o_carry;
    ov_p   = o_overflow;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_mode) i_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic c, input logic s);
    bit acc;
    int g;
    i_valid = 1'b1;
    i_add1  = a;
    i_add2  = b;
    i_carry = c;
    i_sub   = s;
    acc = 1'b0;
    g = 0;
    while (!acc && g < 50) begin
      @(negedge clk);
      acc = o_ready;
      tick();
      g++;
    end
    if (!acc) chk("send_timeout", 64'(acc), 64'd1);
    i_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb_q.size() != 0 && g < 200) begin
      tick();
      g++;
    end
    chk("drain_empty", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    int  lat;
    bit  found, f4, f1;

    repeat (2) tick();
    i_rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_result", o_result, 8'h00);
    chk("rst_carry", o_carry, 1'b0);
    chk("rst_ovf", o_overflow, 1'b0);
    chk("rst_ready", o_ready, 1'b1);
    chk("rst_w4_valid", w4_o_valid, 1'b0);
    chk("rst_w1_valid", w1_o_valid, 1'b0);
    tick();

    send(8'hFF, 8'h01, 1'b0, 1'b0);
    lat = 1;
    found = 1'b0;
    while (!found && lat < 20) begin
      @(negedge clk);
      if (o_valid) found = 1'b1;
      else begin
        tick();
        lat++;
      end
    end
    chk("lat_8x2", 64'(lat), 64'd2);
    chk("ff1_result", o_result, 8'h00);
    chk("ff1_carry", o_carry, 1'b1);
    chk("ff1_ovf", o_overflow, 1'b0);
    tick();

    send(8'h05, 8'h07, 1'b0, 1'b1);
    send(8'h07, 8'h05, 1'b0, 1'b1);
    send(8'h7F, 8'h01, 1'b0, 1'b0);
    send(8'h80, 8'h01, 1'b0, 1'b1);
    send(8'h10, 8'h0F, 1'b1, 1'b1);
    send(8'hF0, 8'h0F, 1'b1, 1'b0);
    drain();

    w_add1  = 64'hFFFF_FFFF_FFFF_FFFF;
    w_add2  = 64'h0;
    w_carry = 1'b1;
    w_valid = 1'b1;
    tick();
    w_valid = 1'b0;
    f4 = 1'b0;
    f1 = 1'b0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      if (!f4 && w4_o_valid) begin
        f4 = 1'b1;
        chk("lat_64x4", 64'(cyc), 64'd4);
        chk("w4_result", w4_o_result, 64'h0);
        chk("w4_carry", w4_o_carry, 1'b1);
      end
      if (!f1 && w1_o_valid) begin
        f1 = 1'b1;
        chk("lat_64x1", 64'(cyc), 64'd1);
        chk("w1_result", w1_o_result, 64'h0);
        chk("w1_carry", w1_o_carry, 1'b1);
      end
      tick();
    end
    chk("w4_seen", 64'(f4), 64'd1);
    chk("w1_seen", 64'(f1), 64'd1);

    rand_mode = 1'b1;
    for (int k = 0; k < 10; k++) begin
      send(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    drain();
    rand_mode = 1'b0;
    i_ready = 1'b1;
    tick();

    i_ready = 1'b0;
    send(8'h11, 8'h22, 1'b0, 1'b0);
    send(8'h33, 8'h44, 1'b1, 1'b1);
    i_valid = 1'b1;
    i_add1  = 8'h55;
    i_add2  = 8'h66;
    i_rst   = 1'b1;
    tick();
    i_rst   = 1'b0;
    i_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", o_valid, 1'b0);
    chk("mid_rst_result", o_result, 8'h00);
    chk("mid_rst_carry", o_carry, 1'b0);
    chk("mid_rst_ovf", o_overflow, 1'b0);
    chk("mid_rst_ready", o_ready, 1'b1);
    i_ready = 1'b1;
    repeat (5) tick();
    send(8'hA5, 8'h5A, 1'b1, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
